fifo_wr_arbiter: RTL and testbench

- Shares the single write port of the team's fifo block among N requesters using round-robin arbitration with a bounded burst per grant.
- Write enable is qualified by the FIFO full flag, so the FIFO is never written while full. This replaces gating the write clock with full.
- Sits directly in front of fifo, in the write-clock domain.

---
 rtl/fifo_arb_pkg.sv | 20 ++
 rtl/fifo_wr_arbiter_rr_pick.sv | 37 +++
 rtl/fifo_wr_arbiter.sv | 129 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter and its
// rotate-priority picker.
package fifo_arb_pkg;

  // Two-state arbiter FSM, kept as plain constants for legacy tools.
  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_GRANT = 1'b1;

  // Width of an index into N requesters (at least one bit).
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Width of a beat counter that spans 0..burst-1 (at least one bit).
  function automatic int cnt_w(input int burst);
    return (burst <= 2) ? 1 : $clog2(burst);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational rotate-priority encoder: returns the first set request bit
// found searching upward from start_i, wrapping from N-1 back to 0.
module rr_pick #(
  parameter int N    = 4,
  parameter int IDXW = 2
) (
  input  logic [N-1:0]    req_i,
  input  logic [IDXW-1:0] start_i,
  output logic [IDXW-1:0] idx_o,
  output logic            valid_o
);

  int unsigned     cand;
  logic [IDXW-1:0] cand_idx;
  logic            found;

  // Walk the N candidate slots in rotated order and keep the first hit.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves
    // it unassigned, which would otherwise infer a latch.
    idx_o    = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 0; i < N; i++) begin
      cand = int'(start_i) + i;
      if (cand >= N) cand = cand - N;
      cand_idx = IDXW'(cand);
      if (!found && req_i[cand_idx]) begin
        found = 1'b1;
        idx_o = cand_idx;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the single FIFO write port among N requesters.
// Each grant allows up to BURST beats; writes are qualified by fifo_full_i.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 4,
  parameter int BURST = 2
) (
  input  logic                    clk,
  input  logic                    rst_ni,
  input  logic [N-1:0]            req_i,
  input  logic [N*WIDTH-1:0]      dat_i,
  output logic [N-1:0]            gnt_o,
  input  logic                    fifo_full_i,
  output logic                    fifo_we_o,
  output logic [WIDTH-1:0]        fifo_dat_o,
  output logic [idx_w(N)-1:0]     owner_o,
  output logic                    busy_o
);

  localparam int IDXW = idx_w(N);
  localparam int CNTW = cnt_w(BURST);

  state_t          fsm_q,    fsm_d;
  logic [IDXW-1:0] owner_q,  owner_d;
  logic [CNTW-1:0] cnt_q,    cnt_d;
  logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;

  logic            in_grant;
  logic            accept;
  logic            burst_end;
  logic            release_own;
  logic [N-1:0]    owner_oh;
  logic [IDXW-1:0] owner_inc;
  logic [N-1:0]    pick_req;
  logic [IDXW-1:0] pick_start;
  logic [IDXW-1:0] pick_idx;
  logic            pick_valid;
  logic [WIDTH-1:0] owner_dat;

  // Decode the owner into a one-hot mask and select its data slice.
  always_comb begin
    owner_oh  = '0;
    owner_dat = '0;
    for (int k = 0; k < N; k++) begin
      if (owner_q == IDXW'(k)) begin
        owner_oh[k] = 1'b1;
        owner_dat   = dat_i[k*WIDTH +: WIDTH];
      end
    end
  end

  // Accept/release qualification and the inputs to the shared picker.
  always_comb begin
    in_grant    = (fsm_q == ST_GRANT);
    accept      = in_grant && req_i[owner_q] && !fifo_full_i && rst_ni;
    burst_end   = accept && (cnt_q == CNTW'(BURST - 1));
    release_own = burst_end || (in_grant && !req_i[owner_q]);
    owner_inc   = (owner_q == IDXW'(N - 1)) ? '0 : owner_q + IDXW'(1);
    // Search after the outgoing owner while granting, else from the pointer.
    pick_start  = in_grant ? owner_inc : rr_ptr_q;
    // Only a burst-limit release hides the outgoing owner from the search.
    pick_req    = burst_end ? (req_i & ~owner_oh) : req_i;
  end

  rr_pick #(
    .N    (N),
    .IDXW (IDXW)
  ) u_pick (
    .req_i   (pick_req),
    .start_i (pick_start),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // Next-state logic for the FSM, owner, beat counter and rr pointer.
  always_comb begin
    fsm_d    = fsm_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    if (fsm_q == ST_IDLE) begin
      if (pick_valid) begin
        fsm_d   = ST_GRANT;
        owner_d = pick_idx;
        cnt_d   = '0;
      end
    end else if (release_own) begin
      rr_ptr_d = owner_inc;
      cnt_d    = '0;
      if (pick_valid) begin
        owner_d = pick_idx;
      end else begin
        fsm_d   = ST_IDLE;
        owner_d = '0;
      end
    end else if (accept) begin
      cnt_d = cnt_q + CNTW'(1);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_ni) begin
      fsm_q    <= ST_IDLE;
      owner_q  <= '0;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      fsm_q    <= fsm_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Outputs: zero-latency write of the owner's beat when accepted.
  always_comb begin
    gnt_o      = accept ? owner_oh : '0;
    fifo_we_o  = accept;
    fifo_dat_o = in_grant ? owner_dat : '0;
    owner_o    = owner_q;
    busy_o     = in_grant;
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (N=4, WIDTH=4, BURST=2). Stimulus
// queues the expected write beats; a monitor pops and checks each write.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic [3:0]  req_i;
  logic [15:0] dat_i;
  logic [3:0]  gnt_o;
  logic        fifo_full_i;
  logic        fifo_we_o;
  logic [3:0]  fifo_dat_o;
  logic [1:0]  owner_o;
  logic        busy_o;

  typedef struct {
    int         owner;
    logic [3:0] dat;
  } beat_t;

  beat_t sb[$];
  int    errors = 0;
  int    checks = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.N(4), .WIDTH(4), .BURST(2)) dut (
    .clk         (clk),
    .rst_ni      (rst_ni),
    .req_i       (req_i),
    .dat_i       (dat_i),
    .gnt_o       (gnt_o),
    .fifo_full_i (fifo_full_i),
    .fifo_we_o   (fifo_we_o),
    .fifo_dat_o  (fifo_dat_o),
    .owner_o     (owner_o),
    .busy_o      (busy_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int owner, input logic [3:0] dat);
    beat_t b;
    b.owner = owner;
    b.dat   = dat;
    sb.push_back(b);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle: check control outputs mid-cycle, then advance past the edge.
  task automatic cyc(input logic eb, input logic ew, input int eo, input string tag);
    logic [3:0] eg;
    @(negedge clk);
    eg = ew ? (4'b0001 << eo) : 4'b0000;
    check({tag, ".busy"},  32'(busy_o),    32'(eb));
    check({tag, ".we"},    32'(fifo_we_o), 32'(ew));
    check({tag, ".owner"}, 32'(owner_o),   32'(eo));
    check({tag, ".gnt"},   32'(gnt_o),     32'(eg));
    if (!eb) check({tag, ".dat_idle"}, 32'(fifo_dat_o), 32'h0);
    tick();
  endtask

  // Scoreboard monitor: every write must match the next queued beat.
  always @(negedge clk) begin
    if (fifo_we_o === 1'b1) begin
      if (sb.size() == 0) begin
        check("sb.unexpected_write", 32'(owner_o), 32'hFFFF_FFFF);
      end else begin
        beat_t b;
        b = sb.pop_front();
        check("sb.owner", 32'(owner_o),    32'(b.owner));
        check("sb.dat",   32'(fifo_dat_o), 32'(b.dat));
        check("sb.gnt",   32'(gnt_o),      32'(4'b0001 << b.owner));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    // Requester data: r0=3, r1=A, r2=6, r3=9.
    rst_ni      = 1'b0;
    req_i       = 4'b0000;
    dat_i       = 16'h96A3;
    fifo_full_i = 1'b0;
    tick();

    // Reset held with all requests asserted.
    req_i = 4'b1111;
    cyc(0, 0, 0, "rst0");
    cyc(0, 0, 0, "rst1");

    // Single requester: two beats, one idle re-arbitration cycle, two beats.
    rst_ni = 1'b1;
    req_i  = 4'b0010;
    repeat (4) push(1, 4'hA);
    cyc(0, 0, 0, "single_arb");
    cyc(1, 1, 1, "single_b0");
    cyc(1, 1, 1, "single_b1");
    cyc(0, 0, 0, "single_rearb");
    cyc(1, 1, 1, "single_b2");
    cyc(1, 1, 1, "single_b3");
    req_i = 4'b0000;
    cyc(0, 0, 0, "single_done");

    // Round robin with all requesting: 0,0,1,1,2,2,3,3,0 back to back.
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    req_i  = 4'b1111;
    push(0, 4'h3); push(0, 4'h3); push(1, 4'hA); push(1, 4'hA);
    push(2, 4'h6); push(2, 4'h6); push(3, 4'h9); push(3, 4'h9);
    push(0, 4'h3);
    cyc(0, 0, 0, "rr_arb");
    begin
      int exp_own [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
      for (int i = 0; i < 9; i++) cyc(1, 1, exp_own[i], "rr_beat");
    end
    req_i = 4'b0000;
    cyc(1, 0, 0, "rr_drop");

    // Full stall mid-burst on owner 2, then release to owner 3.
    req_i = 4'b1100;
    push(2, 4'h6); push(2, 4'h6); push(3, 4'h9); push(3, 4'h9);
    cyc(0, 0, 0, "stall_arb");
    cyc(1, 1, 2, "stall_b0");
    fifo_full_i = 1'b1;
    repeat (3) cyc(1, 0, 2, "stall_full");
    fifo_full_i = 1'b0;
    cyc(1, 1, 2, "stall_b1");
    cyc(1, 1, 3, "stall_o3b0");
    cyc(1, 1, 3, "stall_o3b1");
    req_i = 4'b0000;
    cyc(1, 0, 2, "stall_drop");
    cyc(0, 0, 0, "stall_idle");

    // Early release: owner 1 drops after one beat, requester 3 takes over;
    // requester 1 only returns after 3 and 2 have been served.
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    req_i  = 4'b1010;
    push(1, 4'hA); push(3, 4'h9); push(3, 4'h9); push(2, 4'h6);
    push(2, 4'h6); push(1, 4'hA); push(1, 4'hA);
    cyc(0, 0, 0, "early_arb");
    cyc(1, 1, 1, "early_b0");
    req_i = 4'b1000;
    cyc(1, 0, 1, "early_drop");
    req_i = 4'b1100;
    cyc(1, 1, 3, "early_o3b0");
    cyc(1, 1, 3, "early_o3b1");
    req_i = 4'b0110;
    cyc(1, 1, 2, "early_o2b0");
    cyc(1, 1, 2, "early_o2b1");
    req_i = 4'b0010;
    cyc(1, 1, 1, "early_o1b0");
    cyc(1, 1, 1, "early_o1b1");
    req_i = 4'b0000;
    cyc(0, 0, 0, "early_idle");

    // Reset mid-burst: write suppressed at once, then pointer restarts at 0.
    req_i = 4'b1110;
    push(2, 4'h6); push(1, 4'hA);
    cyc(0, 0, 0, "rstmid_arb");
    cyc(1, 1, 2, "rstmid_b0");
    rst_ni = 1'b0;
    cyc(1, 0, 2, "rstmid_force");
    rst_ni = 1'b1;
    cyc(0, 0, 0, "rstmid_idle");
    cyc(1, 1, 1, "rstmid_low");
    req_i = 4'b0000;
    cyc(1, 0, 1, "rstmid_drop");
    cyc(0, 0, 0, "rstmid_done");

    check("sb.leftover", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
